// File: rtl/sap_sequencer.sv
// sap_sequencer: variable-length microcode sequencer for the SAP-style 8-bit CPU.
// The sequencer steps through a three-cycle fetch, then runs the opcode-specific
// execute states. It also handles run, single-step, halt/resume and illegal opcodes.
// The control word decodes combinationally from the state. In T3 the decode also
// uses the live opcode, and in T4/T5 it uses the opcode latched at the T3->T4 edge.
module sap_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int CTRL_W   = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                step,
  input  logic                resume,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [2:0]          t_state,
  output logic                halted,
  output logic                instr_done,
  output logic                illegal_op
);

  // Control-word bit positions
  localparam logic [14:0] ADDER_EN  = 15'h0001;
  localparam logic [14:0] ADDER_SUB = 15'h0002;
  localparam logic [14:0] B_LOAD    = 15'h0004;
  localparam logic [14:0] A_EN      = 15'h0008;
  localparam logic [14:0] A_LOAD    = 15'h0010;
  localparam logic [14:0] IR_EN     = 15'h0020;
  localparam logic [14:0] IR_LOAD   = 15'h0040;
  localparam logic [14:0] MEM_EN    = 15'h0080;
  localparam logic [14:0] MEM_LOAD  = 15'h0100;
  localparam logic [14:0] PC_EN     = 15'h0200;
  localparam logic [14:0] PC_INC    = 15'h0400;
  localparam logic [14:0] HLT       = 15'h0800;
  localparam logic [14:0] MUL_EN    = 15'h1000;
  localparam logic [14:0] DIV_EN    = 15'h2000;
  localparam logic [14:0] OUT_LOAD  = 15'h4000;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_LDA, C_ADD, C_SUB, C_MUL, C_DIV, C_OUT, C_HLT, C_ILL
  } op_class_t;

  state_t              state_reg;
  logic [OPCODE_W-1:0] op_lat_reg;
  op_class_t           live_class;
  op_class_t           lat_class;
  logic                last_t;
  logic [14:0]         word;

  // Any bit above the low nibble makes the opcode illegal.
  function automatic op_class_t classify(input logic [OPCODE_W-1:0] op);
    op_class_t c;
    c = C_ILL;
    if ((op >> 4) == '0) begin
      case (op[3:0])
        4'h0:    c = C_LDA;
        4'h1:    c = C_ADD;
        4'h2:    c = C_SUB;
        4'h3:    c = C_MUL;
        4'h4:    c = C_DIV;
        4'hE:    c = C_OUT;
        4'hF:    c = C_HLT;
        default: c = C_ILL;
      endcase
    end
    return c;
  endfunction

  assign live_class = classify(opcode);
  assign lat_class  = classify(op_lat_reg);

  // Mark the final T-state of the current instruction. It picks the next fetch or IDLE.
  always_comb begin
    last_t = 1'b0;
    case (state_reg)
      S_T3:    last_t = (live_class == C_OUT) || (live_class == C_HLT) ||
                        (live_class == C_ILL);
      S_T4:    last_t = (lat_class == C_LDA);
      S_T5:    last_t = 1'b1;
      default: last_t = 1'b0;
    endcase
  end

  // State sequencing and opcode latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      op_lat_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (run || step) state_reg <= S_T0;
        S_T0:   state_reg <= S_T1;
        S_T1:   state_reg <= S_T2;
        S_T2:   state_reg <= S_T3;
        S_T3: begin
          op_lat_reg <= opcode;
          if (live_class == C_HLT) state_reg <= S_HALT;
          else if (last_t)         state_reg <= run ? S_T0 : S_IDLE;
          else                     state_reg <= S_T4;
        end
        S_T4: begin
          if (last_t) state_reg <= run ? S_T0 : S_IDLE;
          else        state_reg <= S_T5;
        end
        S_T5:   state_reg <= run ? S_T0 : S_IDLE;
        S_HALT: if (resume) state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Microcode decode of the control word
  always_comb begin
    word = '0;
    case (state_reg)
      S_T0: word = PC_EN | MEM_LOAD;
      S_T1: word = PC_INC;
      S_T2: word = MEM_EN | IR_LOAD;
      S_T3: begin
        case (live_class)
          C_LDA, C_ADD, C_SUB, C_MUL, C_DIV: word = IR_EN | MEM_LOAD;
          C_OUT:   word = A_EN | OUT_LOAD;
          C_HLT:   word = HLT;
          default: word = '0;
        endcase
      end
      S_T4: word = (lat_class == C_LDA) ? (MEM_EN | A_LOAD) : (MEM_EN | B_LOAD);
      S_T5: begin
        case (lat_class)
          C_ADD:   word = ADDER_EN | A_LOAD;
          C_SUB:   word = ADDER_EN | ADDER_SUB | A_LOAD;
          C_MUL:   word = MUL_EN | A_LOAD;
          C_DIV:   word = DIV_EN | A_LOAD;
          default: word = '0;
        endcase
      end
      S_HALT:  word = HLT;
      default: word = '0;
    endcase
  end

  // Widen the control word. Bits above 14 stay zero.
  always_comb begin
    ctrl       = '0;
    ctrl[14:0] = word;
  end

  // Status outputs
  always_comb begin
    t_state = 3'd7;
    case (state_reg)
      S_T0:    t_state = 3'd0;
      S_T1:    t_state = 3'd1;
      S_T2:    t_state = 3'd2;
      S_T3:    t_state = 3'd3;
      S_T4:    t_state = 3'd4;
      S_T5:    t_state = 3'd5;
      default: t_state = 3'd7;
    endcase
    halted     = (state_reg == S_HALT);
    instr_done = last_t;
    illegal_op = (state_reg == S_T3) && (live_class == C_ILL);
  end

endmodule

// File: tb/tb_sap_sequencer.sv
// Testbench for sap_sequencer. The directed steps follow the instruction
// scenarios, then a randomized phase runs. Each cycle is checked against an
// instruction-level model. That model tracks the mode, the position within the
// instruction and the instruction length.
module tb_sap_sequencer;
  localparam int OW = 6;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          resume = 1'b0;
  logic [OW-1:0] opcode = '0;
  logic [CW-1:0] ctrl;
  logic [2:0]    t_state;
  logic          halted;
  logic          instr_done;
  logic          illegal_op;

  int errors = 0;
  int checks = 0;

  // Model state: mode 0 idle, 1 executing, 2 halted.
  int            m_mode = 0;
  int            m_k = 0;
  logic [OW-1:0] m_op = '0;

  always #5 clk = ~clk;

  sap_sequencer #(.OPCODE_W(OW), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .resume(resume),
    .opcode(opcode), .ctrl(ctrl), .t_state(t_state), .halted(halted),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  function automatic bit legal(input int op);
    return (op <= 4) || (op == 14) || (op == 15);
  endfunction

  function automatic int ilen(input int op);
    if (op == 0) return 5;
    if (op >= 1 && op <= 4) return 6;
    return 4;
  endfunction

  function automatic int uword(input int op, input int k);
    case (k)
      0: return 'h300;
      1: return 'h400;
      2: return 'h0C0;
      3: begin
        if (op <= 4) return 'h120;
        if (op == 14) return 'h4008;
        if (op == 15) return 'h800;
        return 0;
      end
      4: return (op == 0) ? 'h090 : 'h084;
      5: case (op)
           1: return 'h011;
           2: return 'h013;
           3: return 'h1010;
           4: return 'h2010;
           default: return 0;
         endcase
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    int op;
    int e_ctrl, e_t, e_h, e_d, e_i;
    op = (m_k == 3) ? int'(opcode) : int'(m_op);
    e_ctrl = 0; e_t = 7; e_h = 0; e_d = 0; e_i = 0;
    if (m_mode == 2) begin
      e_ctrl = 'h800; e_h = 1;
    end else if (m_mode == 1) begin
      e_ctrl = uword(op, m_k);
      e_t    = m_k;
      e_d    = (m_k == ilen(op) - 1) ? 1 : 0;
      e_i    = (m_k == 3 && !legal(op)) ? 1 : 0;
    end
    chk("ctrl", 32'(ctrl), 32'(e_ctrl));
    chk("t_state", 32'(t_state), 32'(e_t));
    chk("halted", 32'(halted), 32'(e_h));
    chk("instr_done", 32'(instr_done), 32'(e_d));
    chk("illegal_op", 32'(illegal_op), 32'(e_i));
  endtask

  task automatic model_edge();
    int op;
    if (!rst_n) begin
      m_mode = 0; m_k = 0; m_op = '0;
    end else begin
      case (m_mode)
        0: if (run || step) begin m_mode = 1; m_k = 0; end
        1: begin
          op = (m_k == 3) ? int'(opcode) : int'(m_op);
          if (m_k == 3) m_op = opcode;
          if (m_k == ilen(op) - 1) begin
            if (op == 15) m_mode = 2;
            else if (run) m_k = 0;
            else m_mode = 0;
          end else begin
            m_k++;
          end
        end
        default: if (resume) m_mode = 0;
      endcase
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic do_cyc(input int xc);
    @(negedge clk);
    check_model();
    if (xc >= 0) chk("directed_ctrl", 32'(ctrl), 32'(xc));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    int r;
    #1;
    check_model();
    do_cyc(0);
    do_cyc(0);
    rst_n = 1'b1;

    // LDA under run, then each ALU op; opcode changes to 0xF during T4.
    run = 1'b1; opcode = 6'h00;
    do_cyc(0);
    do_cyc('h300); do_cyc('h400); do_cyc('h0C0); do_cyc('h120); do_cyc('h090);
    for (int op = 1; op <= 4; op++) begin
      opcode = 6'(op);
      do_cyc('h300); do_cyc('h400); do_cyc('h0C0); do_cyc('h120);
      opcode = 6'h0F;
      do_cyc('h084);
      if (op == 4) run = 1'b0;
      do_cyc(uword(op, 5));
    end
    do_cyc(0);

    // Single step of OUT. A second step mid-instruction is ignored.
    step = 1'b1; opcode = 6'h0E;
    do_cyc(0);
    step = 1'b0; do_cyc('h300);
    step = 1'b1; do_cyc('h400);
    step = 1'b0; do_cyc('h0C0);
    do_cyc('h4008);
    do_cyc(0);
    do_cyc(0);

    // HLT, held against step, then resume under run.
    step = 1'b1; opcode = 6'h0F;
    do_cyc(0);
    step = 1'b0;
    do_cyc('h300); do_cyc('h400); do_cyc('h0C0); do_cyc('h800);
    for (int i = 0; i < 10; i++) begin
      step = ~step;
      do_cyc('h800);
    end
    step = 1'b0; run = 1'b1; resume = 1'b1;
    do_cyc('h800);
    resume = 1'b0;
    do_cyc(0);

    // Illegal opcodes: 0x07, then 0x11 with an upper bit set.
    opcode = 6'h07;
    do_cyc('h300); do_cyc('h400); do_cyc('h0C0); do_cyc(0);
    opcode = 6'h11;
    do_cyc('h300); do_cyc('h400); do_cyc('h0C0);
    run = 1'b0;
    do_cyc(0);
    do_cyc(0);

    // Asynchronous reset during T4 of ADD
    run = 1'b1; opcode = 6'h01;
    do_cyc(0);
    do_cyc('h300); do_cyc('h400); do_cyc('h0C0); do_cyc('h120);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 32'(ctrl), 32'h0);
    chk("async_rst_t_state", 32'(t_state), 32'd7);
    m_mode = 0; m_k = 0; m_op = '0;
    do_cyc(0);
    rst_n = 1'b1; run = 1'b0;
    do_cyc(0);
    do_cyc(0);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      run    = ($urandom_range(0, 9) != 0);
      step   = ($urandom_range(0, 3) == 0);
      resume = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 23));
      opcode = (r < 16) ? 6'(r) : 6'($urandom_range(0, 63));
      do_cyc(-1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
